// File: rtl/pkt_mux_fifo_if.sv
// Packet bundle for pkt_mux_fifo: inputs A (8b), B (16b), C (32b) with
// vld/sop/eop/mty qualifiers and tagged 16-bit output D; slave = DUT side.
interface pkt_mux_fifo_if;
  logic [7:0]  data_a;
  logic        data_a_vld;
  logic        data_a_sop;
  logic        data_a_eop;
  logic [15:0] data_b;
  logic        data_b_vld;
  logic        data_b_sop;
  logic        data_b_eop;
  logic [1:0]  data_b_mty;
  logic [31:0] data_c;
  logic        data_c_vld;
  logic        data_c_sop;
  logic        data_c_eop;
  logic [1:0]  data_c_mty;
  logic [15:0] data_d;
  logic        data_d_vld;
  logic        data_d_sop;
  logic        data_d_eop;
  logic        data_d_mty;
  logic [1:0]  chan_d;

  modport master (
    output data_a, data_a_vld, data_a_sop, data_a_eop,
    output data_b, data_b_vld, data_b_sop, data_b_eop, data_b_mty,
    output data_c, data_c_vld, data_c_sop, data_c_eop, data_c_mty,
    input  data_d, data_d_vld, data_d_sop, data_d_eop, data_d_mty,
    input  chan_d
  );

  modport slave (
    input  data_a, data_a_vld, data_a_sop, data_a_eop,
    input  data_b, data_b_vld, data_b_sop, data_b_eop, data_b_mty,
    input  data_c, data_c_vld, data_c_sop, data_c_eop, data_c_mty,
    output data_d, data_d_vld, data_d_sop, data_d_eop, data_d_mty,
    output chan_d
  );
endinterface

// File: rtl/pkt_mux_fifo.sv
// Three-channel packet aggregator: per-channel store-and-forward FIFOs,
// round-robin arbiter, whole packets out on 16-bit port D tagged by chan_d.
// Ports: clk, rst (async active-high), bus (pkt_mux_fifo_if.slave).
// Option: INTER_PKT_GAP_EN forces an idle cycle between output packets.
module pkt_mux_fifo #(
  parameter int DEPTH_A   = 64,
  parameter int DEPTH_B   = 64,
  parameter int DEPTH_C   = 32,
  parameter int MAX_PKT_A = 32,
  parameter int MAX_PKT_B = 32,
  parameter int MAX_PKT_C = 16
) (
  input logic           clk,
  input logic           rst,
  pkt_mux_fifo_if.slave bus
);
  localparam int AWA = $clog2(DEPTH_A);
  localparam int AWB = $clog2(DEPTH_B);
  localparam int AWC = $clog2(DEPTH_C);
  localparam int CWA = $clog2(DEPTH_A + 1);
  localparam int CWB = $clog2(DEPTH_B + 1);
  localparam int CWC = $clog2(DEPTH_C + 1);
  // admit when occupancy <= depth - max packet
  localparam logic [CWA-1:0] LIMA = CWA'(DEPTH_A - MAX_PKT_A);
  localparam logic [CWB-1:0] LIMB = CWB'(DEPTH_B - MAX_PKT_B);
  localparam logic [CWC-1:0] LIMC = CWC'(DEPTH_C - MAX_PKT_C);
  localparam logic [AWA-1:0] TOPA = AWA'(DEPTH_A - 1);
  localparam logic [AWB-1:0] TOPB = AWB'(DEPTH_B - 1);
  localparam logic [AWC-1:0] TOPC = AWC'(DEPTH_C - 1);

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] SEND = 1'b1;
`ifdef INTER_PKT_GAP_EN
  localparam logic CHAIN = 1'b0;
`else
  localparam logic CHAIN = 1'b1;
`endif

  // entries: {eop, mty, data}
  logic [17:0] mem_a [DEPTH_A];
  logic [17:0] mem_b [DEPTH_B];
  logic [34:0] mem_c [DEPTH_C];

  logic [AWA-1:0] wp_a, rp_a;
  logic [AWB-1:0] wp_b, rp_b;
  logic [AWC-1:0] wp_c, rp_c;
  logic [CWA-1:0] cnt_a, pc_a;
  logic [CWB-1:0] cnt_b, pc_b;
  logic [CWC-1:0] cnt_c, pc_c;
  logic in_a, in_b, in_c;
  logic drop_a, drop_b, drop_c;
  logic hb_a;
  logic [7:0] hold_a;

  logic st_a, st_b, st_c;
  logic ok_a, ok_b, ok_c;
  logic fb_a, wr_a, wr_b, wr_c;
  logic [17:0] we_a, we_b;
  logic [34:0] we_c;
  logic unused_mty;

  logic [0:0] state;
  logic [1:0] chan;
  logic half, sop_nx;
  logic send, w_eop, w_mty, any;
  logic rd_a, rd_b, rd_c;
  logic dec_a, dec_b, dec_c;
  logic [15:0] w_dat;
  logic [2:0] el;
  logic [1:0] pick;
  logic [17:0] ea, eb;
  logic [34:0] ec;

  assign unused_mty = bus.data_b_mty[1];

  // round-robin: search starts after the last-served channel
  function automatic logic [1:0] rr(
    input logic [2:0] e,
    input logic [1:0] last
  );
    logic [1:0] r;
    r = 2'd0;
    unique case (last)
      2'd0:    r = e[1] ? 2'd1 : (e[2] ? 2'd2 : 2'd0);
      2'd1:    r = e[2] ? 2'd2 : (e[0] ? 2'd0 : 2'd1);
      default: r = e[0] ? 2'd0 : (e[1] ? 2'd1 : 2'd2);
    endcase
    return r;
  endfunction

  always_comb begin
    st_a = bus.data_a_vld & ~in_a & bus.data_a_sop;
    st_b = bus.data_b_vld & ~in_b & bus.data_b_sop;
    st_c = bus.data_c_vld & ~in_c & bus.data_c_sop;
    ok_a = bus.data_a_vld &
           (st_a ? (cnt_a <= LIMA) : (in_a & ~drop_a));
    ok_b = bus.data_b_vld &
           (st_b ? (cnt_b <= LIMB) : (in_b & ~drop_b));
    ok_c = bus.data_c_vld &
           (st_c ? (cnt_c <= LIMC) : (in_c & ~drop_c));
    // A packer: first byte of a pair is held unless it ends the packet
    fb_a = st_a | ~hb_a;
    wr_a = ok_a & (bus.data_a_eop | ~fb_a);
    we_a = fb_a ? {bus.data_a_eop, 1'b1, bus.data_a, 8'h00}
                : {bus.data_a_eop, 1'b0, hold_a, bus.data_a};
    wr_b = ok_b;
    we_b = {bus.data_b_eop, bus.data_b_eop & bus.data_b_mty[0],
            bus.data_b};
    wr_c = ok_c;
    we_c = {bus.data_c_eop,
            bus.data_c_eop ? bus.data_c_mty : 2'b00, bus.data_c};
  end

  assign ea = mem_a[rp_a];
  assign eb = mem_b[rp_b];
  assign ec = mem_c[rp_c];

  always_comb begin
    send  = state == SEND;
    w_dat = '0;
    w_eop = 1'b0;
    w_mty = 1'b0;
    rd_a  = 1'b0;
    rd_b  = 1'b0;
    rd_c  = 1'b0;
    unique case (1'b1)
      chan == 2'd0: begin
        w_dat = ea[15:0];
        w_mty = ea[16];
        w_eop = ea[17];
        rd_a  = send;
      end
      chan == 2'd1: begin
        w_dat = eb[15:0];
        w_mty = eb[16];
        w_eop = eb[17];
        rd_b  = send;
      end
      default: begin
        // C: upper half ends the packet only for mty 2/3
        if (!half) begin
          w_dat = ec[31:16];
          w_eop = ec[34] & ec[33];
          w_mty = ec[34] & ec[33] & ec[32];
        end else begin
          w_dat = ec[15:0];
          w_eop = ec[34];
          w_mty = ec[34] & ec[32];
        end
        rd_c = send & (half | w_eop);
      end
    endcase
    dec_a = send & w_eop & (chan == 2'd0);
    dec_b = send & w_eop & (chan == 2'd1);
    dec_c = send & w_eop & (chan == 2'd2);
    // a packet finishing this cycle no longer counts as eligible
    el = {pc_c > CWC'(dec_c), pc_b > CWB'(dec_b), pc_a > CWA'(dec_a)};
    any  = |el;
    pick = rr(el, chan);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      in_a   <= 1'b0;
      drop_a <= 1'b0;
      hb_a   <= 1'b0;
      hold_a <= '0;
      wp_a   <= '0;
      rp_a   <= '0;
      cnt_a  <= '0;
      pc_a   <= '0;
    end else begin
      if (st_a) begin
        in_a   <= ~bus.data_a_eop;
        drop_a <= ~(cnt_a <= LIMA);
      end else if (bus.data_a_vld & in_a & bus.data_a_eop) begin
        in_a <= 1'b0;
      end
      if (ok_a) begin
        hb_a <= fb_a & ~bus.data_a_eop;
        if (fb_a) hold_a <= bus.data_a;
      end
      if (wr_a) wp_a <= (wp_a == TOPA) ? '0 : wp_a + AWA'(1);
      if (rd_a) rp_a <= (rp_a == TOPA) ? '0 : rp_a + AWA'(1);
      cnt_a <= cnt_a + CWA'(wr_a) - CWA'(rd_a);
      pc_a  <= pc_a + CWA'(wr_a & we_a[17]) - CWA'(dec_a);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      in_b   <= 1'b0;
      drop_b <= 1'b0;
      wp_b   <= '0;
      rp_b   <= '0;
      cnt_b  <= '0;
      pc_b   <= '0;
    end else begin
      if (st_b) begin
        in_b   <= ~bus.data_b_eop;
        drop_b <= ~(cnt_b <= LIMB);
      end else if (bus.data_b_vld & in_b & bus.data_b_eop) begin
        in_b <= 1'b0;
      end
      if (wr_b) wp_b <= (wp_b == TOPB) ? '0 : wp_b + AWB'(1);
      if (rd_b) rp_b <= (rp_b == TOPB) ? '0 : rp_b + AWB'(1);
      cnt_b <= cnt_b + CWB'(wr_b) - CWB'(rd_b);
      pc_b  <= pc_b + CWB'(wr_b & we_b[17]) - CWB'(dec_b);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      in_c   <= 1'b0;
      drop_c <= 1'b0;
      wp_c   <= '0;
      rp_c   <= '0;
      cnt_c  <= '0;
      pc_c   <= '0;
    end else begin
      if (st_c) begin
        in_c   <= ~bus.data_c_eop;
        drop_c <= ~(cnt_c <= LIMC);
      end else if (bus.data_c_vld & in_c & bus.data_c_eop) begin
        in_c <= 1'b0;
      end
      if (wr_c) wp_c <= (wp_c == TOPC) ? '0 : wp_c + AWC'(1);
      if (rd_c) rp_c <= (rp_c == TOPC) ? '0 : rp_c + AWC'(1);
      cnt_c <= cnt_c + CWC'(wr_c) - CWC'(rd_c);
      pc_c  <= pc_c + CWC'(wr_c & we_c[34]) - CWC'(dec_c);
    end
  end

  always_ff @(posedge clk) begin
    if (wr_a) mem_a[wp_a] <= we_a;
    if (wr_b) mem_b[wp_b] <= we_b;
    if (wr_c) mem_c[wp_c] <= we_c;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state          <= IDLE;
      chan           <= 2'd2;
      half           <= 1'b0;
      sop_nx         <= 1'b0;
      bus.data_d     <= '0;
      bus.data_d_vld <= 1'b0;
      bus.data_d_sop <= 1'b0;
      bus.data_d_eop <= 1'b0;
      bus.data_d_mty <= 1'b0;
      bus.chan_d     <= '0;
    end else begin
      bus.data_d     <= send ? w_dat : '0;
      bus.data_d_vld <= send;
      bus.data_d_sop <= send & sop_nx;
      bus.data_d_eop <= send & w_eop;
      bus.data_d_mty <= send & w_mty;
      bus.chan_d     <= send ? chan : 2'd0;
      if (!send) begin
        if (any) begin
          state  <= SEND;
          chan   <= pick;
          half   <= 1'b0;
          sop_nx <= 1'b1;
        end
      end else begin
        sop_nx <= 1'b0;
        half   <= ~half & ~w_eop;
        if (w_eop) begin
          // chain straight into the next grant for back-to-back output
          if (CHAIN && any) begin
            chan   <= pick;
            sop_nx <= 1'b1;
          end else begin
            state <= IDLE;
          end
        end
      end
    end
  end
endmodule

// File: tb/tb_pkt_mux_fifo.sv
// Directed self-checking bench for pkt_mux_fifo.
// Captures output words at negedge and compares against hand-built lists.
module tb_pkt_mux_fifo;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  pkt_mux_fifo_if bus();
  pkt_mux_fifo dut (.clk(clk), .rst(rst), .bus(bus));

`ifdef INTER_PKT_GAP_EN
  localparam time PGAP = 20;
`else
  localparam time PGAP = 10;
`endif

  int checks = 0;
  int errors = 0;
  time t_edge, t_eop;
  logic [20:0] qv[$];
  time qt[$];
  logic [20:0] ev[$];

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [20:0] w(input logic [1:0] c, input logic s,
      input logic e, input logic m, input logic [15:0] d);
    return {c, s, e, m, d};
  endfunction

  always @(negedge clk) begin
    if (bus.data_d_vld === 1'b1) begin
      qv.push_back({bus.chan_d, bus.data_d_sop, bus.data_d_eop,
                    bus.data_d_mty, bus.data_d});
      qt.push_back($time - 5);
    end
  end

  function automatic logic [21:0] outs();
    return {bus.data_d_vld, bus.data_d_sop, bus.data_d_eop,
            bus.data_d_mty, bus.chan_d, bus.data_d};
  endfunction

  task automatic tick();
    @(posedge clk);
    t_edge = $time;
    #1;
    bus.data_a_vld = 0; bus.data_a_sop = 0; bus.data_a_eop = 0;
    bus.data_b_vld = 0; bus.data_b_sop = 0; bus.data_b_eop = 0;
    bus.data_c_vld = 0; bus.data_c_sop = 0; bus.data_c_eop = 0;
    bus.data_b_mty = 0; bus.data_c_mty = 0;
  endtask

  task automatic ba(input logic [7:0] d, input logic s, input logic e);
    bus.data_a = d; bus.data_a_vld = 1;
    bus.data_a_sop = s; bus.data_a_eop = e;
  endtask

  task automatic bb(input logic [15:0] d, input logic s, input logic e,
                    input logic [1:0] m);
    bus.data_b = d; bus.data_b_vld = 1;
    bus.data_b_sop = s; bus.data_b_eop = e; bus.data_b_mty = m;
  endtask

  task automatic bc(input logic [31:0] d, input logic s, input logic e,
                    input logic [1:0] m);
    bus.data_c = d; bus.data_c_vld = 1;
    bus.data_c_sop = s; bus.data_c_eop = e; bus.data_c_mty = m;
  endtask

  task automatic do_reset();
    rst = 1;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_outs", outs(), 0);
    rst = 0;
    @(posedge clk);
    #1;
    qv.delete(); qt.delete();
  endtask

  // wait for the expected words, then verify content, latency, spacing
  task automatic check_out(input string tag);
    int n;
    int bad;
    time g;
    n = 0;
    while (qv.size() < ev.size() && n < 400) begin
      @(posedge clk);
      n++;
    end
    repeat (10) @(posedge clk);
    #1;
    chk({tag, "_len"}, qv.size(), ev.size());
    for (int i = 0; i < ev.size() && i < qv.size(); i++)
      chk($sformatf("%s_w%0d", tag, i), qv[i], ev[i]);
    if (qt.size() > 0) chk({tag, "_lat"}, qt[0] - t_eop, 20);
    bad = 0;
    for (int i = 1; i < ev.size() && i < qt.size(); i++) begin
      g = ev[i][18] ? PGAP : 10;
      if (qt[i] - qt[i-1] != g) bad++;
    end
    chk({tag, "_gap"}, bad, 0);
    qv.delete(); qt.delete(); ev.delete();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    bus.data_a = 0; bus.data_b = 0; bus.data_c = 0;
    bus.data_a_vld = 0; bus.data_a_sop = 0; bus.data_a_eop = 0;
    bus.data_b_vld = 0; bus.data_b_sop = 0; bus.data_b_eop = 0;
    bus.data_c_vld = 0; bus.data_c_sop = 0; bus.data_c_eop = 0;
    bus.data_b_mty = 0; bus.data_c_mty = 0;
    rst = 1;
    #2;
    chk("async_reset", outs(), 0);
    do_reset();

    // A: 32 bytes -> 16 packed words
    for (int i = 0; i < 32; i++) begin
      ba(8'(i), i == 0, i == 31);
      tick();
    end
    t_eop = t_edge;
    for (int j = 0; j < 16; j++)
      ev.push_back(w(0, j == 0, j == 15, 0, {8'(2*j), 8'(2*j+1)}));
    check_out("a32");

    // A: odd length, last word padded
    ba(8'hAA, 1, 0); tick();
    ba(8'hBB, 0, 0); tick();
    ba(8'hCC, 0, 1); tick();
    t_eop = t_edge;
    ev.push_back(w(0, 1, 0, 0, 16'hAABB));
    ev.push_back(w(0, 0, 1, 1, 16'hCC00));
    check_out("a3");

    // B: 32 words, eop mty=1
    for (int i = 0; i < 32; i++) begin
      bb(16'hB000 + 16'(i), i == 0, i == 31, (i == 31) ? 2'd1 : 2'd0);
      tick();
    end
    t_eop = t_edge;
    for (int i = 0; i < 32; i++)
      ev.push_back(w(1, i == 0, i == 31, i == 31, 16'hB000 + 16'(i)));
    check_out("b32");

    // C: 32 words, eop mty=2 then mty=3
    for (int m = 2; m < 4; m++) begin
      for (int i = 0; i < 32; i++) begin
        bc({16'hC000 + 16'(2*i), 16'hC000 + 16'(2*i+1)},
           i == 0, i == 31, (i == 31) ? 2'(m) : 2'd0);
        tick();
      end
      t_eop = t_edge;
      for (int i = 0; i < 31; i++) begin
        ev.push_back(w(2, i == 0, 0, 0, 16'hC000 + 16'(2*i)));
        ev.push_back(w(2, 0, 0, 0, 16'hC000 + 16'(2*i+1)));
      end
      ev.push_back(w(2, 0, 1, m == 3, 16'hC03E));
      check_out(m == 2 ? "c_mty2" : "c_mty3");
    end

    // A, B, C complete together -> A, B, C order
    do_reset();
    ba(8'h11, 1, 0); tick();
    ba(8'h22, 0, 1);
    bb(16'h3344, 1, 1, 0);
    bc(32'h5566_7788, 1, 1, 0);
    tick();
    t_eop = t_edge;
    ev.push_back(w(0, 1, 1, 0, 16'h1122));
    ev.push_back(w(1, 1, 1, 0, 16'h3344));
    ev.push_back(w(2, 1, 0, 0, 16'h5566));
    ev.push_back(w(2, 0, 1, 0, 16'h7788));
    check_out("abc");

    // B: 40-word packet leaves 24 free -> next packet dropped
    for (int i = 0; i < 40; i++) begin
      bb(16'h4000 + 16'(i), i == 0, i == 39, 0);
      tick();
    end
    t_eop = t_edge;
    for (int i = 0; i < 5; i++) begin
      bb(16'hDEAD, i == 0, i == 4, 0);
      tick();
    end
    for (int i = 0; i < 40; i++)
      ev.push_back(w(1, i == 0, i == 39, 0, 16'h4000 + 16'(i)));
    check_out("b_drop");
    for (int i = 0; i < 3; i++) begin
      bb(16'h7000 + 16'(i), i == 0, i == 2, 0);
      tick();
    end
    t_eop = t_edge;
    for (int i = 0; i < 3; i++)
      ev.push_back(w(1, i == 0, i == 2, 0, 16'h7000 + 16'(i)));
    check_out("b_after");

    // reset in the middle of a packet
    for (int i = 0; i < 32; i++) begin
      ba(8'(i), i == 0, i == 31);
      tick();
    end
    n = 0;
    while (qv.size() < 4 && n < 50) begin
      @(posedge clk);
      n++;
    end
    chk("mid_started", qv.size() >= 4, 1);
    @(negedge clk);
    #2;
    rst = 1;
    #1;
    chk("mid_rst_outs", outs(), 0);
    repeat (2) @(posedge clk);
    #1;
    rst = 0;
    qv.delete(); qt.delete();
    repeat (20) @(posedge clk);
    #1;
    chk("post_rst_idle", qv.size(), 0);
    bb(16'h9001, 1, 0, 0); tick();
    bb(16'h9002, 0, 1, 1); tick();
    t_eop = t_edge;
    ev.push_back(w(1, 1, 0, 0, 16'h9001));
    ev.push_back(w(1, 0, 1, 1, 16'h9002));
    check_out("b_post_rst");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
